lfsr_bus_datapath: RTL
======================

# lfsr_bus_datapath

Datapath stage paired with the bus-interface control FSM. It decodes the bus address against the block's fixed address and returns `A_eq_Faddr` to the controller. It consumes the controller's `Den` and, on each qualified read, drives the current pseudo-random word from an internal Fibonacci LFSR onto the bus. It also keeps a transfer count and supports run-time seed loading.

## Interface
- `AW`, 8, address width
- `DW`, 8, data/LFSR width (≥ 3)
- `FADDR`, 8'hA5, address this block responds to (AW bits)
- `SEED`, 8'h01, reset value of the LFSR; also the substitute for an all-zero seed (DW bits, non-zero)
- `TAPS`, 8'hB8, feedback tap mask (x^8+x^6+x^5+x^4+1; maximal length 255 for DW=8)

- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `addr` in AW: bus address
- `rd` in 1: bus read strobe
- `Den` in 1: data enable from the control FSM
- `ld` in 1: seed-load strobe
- `seed_in` in DW: seed value for `ld`
- `A_eq_Faddr` out 1: registered address match, to the control FSM
- `data_bus` out DW: registered read data
- `dvalid` out 1: one-cycle pulse marking a new word on `data_bus`
- `xfer_cnt` out 8: count of completed transfers, wraps

## Operation
- **Address decode.** `A_eq_Faddr` <= (`addr` == `FADDR`) every clock.
- **Transfer.** A transfer occurs in any cycle where `Den`=1 and `rd`=1, sampled at the rising edge. On a transfer:
  - `data_bus` <= current `lfsr`
  - `dvalid` <= 1
  - `lfsr` <= `step(lfsr)`
  - `xfer_cnt` <= `xfer_cnt`+1 (mod 256, 8'hFF → 8'h00)
- **No transfer.** `dvalid` <= 0. `data_bus`, `lfsr` and `xfer_cnt` hold.
- **LFSR step.**
  - fb = XOR-reduce(`lfsr` & `TAPS`)
  - `step(x)` = {x[DW-2:0], fb}
  - From 8'h01 with default taps the sequence is 01, 02, 04, 08, 11, 23, 47, …
- **Seed load.**
  - `ld`=1 loads `lfsr` <= `seed_in`.
  - If `seed_in`==0, `lfsr` <= `SEED` instead. The all-zero lock-up state must never be entered.
- **Simultaneous `ld` and transfer.** The transfer outputs the pre-load `lfsr` value on `data_bus` and `dvalid` pulses. `xfer_cnt` increments. `lfsr` takes the seed, so the load has priority over the step.
- **`Den`=0.** `rd` is ignored; there is no transfer and no LFSR advance.
- **`rd`=1 with `Den`=0.** No effect on the datapath.

## Timing
- **Reset values** (asserted asynchronously, immediately on `rst` rise):
  - `lfsr`=`SEED`
  - `data_bus`=0
  - `dvalid`=0
  - `xfer_cnt`=0
  - `A_eq_Faddr`=0
- **Release.** Registers update from the first rising edge after `rst` falls.
- **Address-match latency.** `A_eq_Faddr` lags `addr` by 1 cycle.
- **Read latency.** 1 cycle. Transfer sampled at edge N → `data_bus`/`dvalid` valid after edge N, through edge N+1.
- **Back-to-back transfers.** `Den`=`rd`=1 for K consecutive edges yields K consecutive `dvalid` cycles with successive LFSR words and no bubbles.
- **Seed latency.** A seed loaded at edge N is the word output by a transfer at edge N+1 or later.
- **Reset mid-burst.** Outputs drop to reset values immediately. The LFSR restarts at `SEED`; any pre-reset load is lost.

## Test plan
1. **Reset.** Assert `rst` asynchronously between edges mid-burst → all outputs 0 at once, `lfsr`=8'h01. After release, first transfer gives `data_bus`=8'h01.
2. **Burst.** `Den`=`rd`=1 for 6 edges → `data_bus` = 01, 02, 04, 08, 11, 23 with `dvalid` high for 6 consecutive cycles; `xfer_cnt`=6.
3. **Gating.** `rd`=1, `Den`=0 for 4 edges → `dvalid` stays 0, `data_bus` and `xfer_cnt` unchanged, next transfer returns the un-advanced word.
4. **Seed load.**
   - `ld`=1, `seed_in`=8'h5A, then one transfer → `data_bus`=8'h5A.
   - `ld`=1, `seed_in`=0, then one transfer → `data_bus`=8'h01.
   - `ld` coincident with a transfer → output is the old word, next transfer outputs the seed.
5. **Address decode and period.**
   - `addr`=8'hA5 → `A_eq_Faddr`=1 one cycle later; `addr`=8'hA4 → 0 one cycle later.
   - 255 transfers from 8'h01 → LFSR returns to 8'h01 and no word repeats earlier.
   - 256 transfers → `xfer_cnt` wraps to 8'h00.

Source files
------------

// File: rtl/lfsr_bus_datapath.sv
// Read datapath for the bus-interface controller: address decode back to the FSM,
// and a Fibonacci LFSR whose current word is driven onto the bus on each qualified read.
module lfsr_bus_datapath #(
    parameter int              AW    = 8,
    parameter int              DW    = 8,
    parameter logic [AW-1:0]   FADDR = 8'hA5,
    parameter logic [DW-1:0]   SEED  = 8'h01,
    parameter logic [DW-1:0]   TAPS  = 8'hB8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr,
    input  logic          rd,
    input  logic          Den,
    input  logic          ld,
    input  logic [DW-1:0] seed_in,
    output logic          A_eq_Faddr,
    output logic [DW-1:0] data_bus,
    output logic          dvalid,
    output logic [7:0]    xfer_cnt
);

    // Handshake: a transfer is Den & rd at a rising edge; the word appears on
    // data_bus with dvalid high for exactly the following cycle.

    logic [DW-1:0] lfsr;
    logic [DW-1:0] lfsr_nxt;
    logic [DW-1:0] load_val;
    logic          xfer;

    function automatic logic [DW-1:0] lfsr_step(input logic [DW-1:0] x);
        logic fb;
        fb = ^(x & TAPS);
        return {x[DW-2:0], fb};
    endfunction

    assign xfer = Den & rd;

    // A zero seed would lock the register up, so it is replaced by SEED.
    assign load_val = (seed_in == '0) ? SEED : seed_in;

    // Load wins over step when both happen in the same cycle.
    always_comb begin
        lfsr_nxt = lfsr;
        if (ld) begin
            lfsr_nxt = load_val;
        end else if (xfer) begin
            lfsr_nxt = lfsr_step(lfsr);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= SEED;
        end else begin
            lfsr <= lfsr_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            A_eq_Faddr <= 1'b0;
        end else begin
            A_eq_Faddr <= (addr == FADDR);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_bus <= '0;
            dvalid   <= 1'b0;
            xfer_cnt <= 8'h00;
        end else begin
            dvalid <= xfer;
            if (xfer) begin
                data_bus <= lfsr;
                xfer_cnt <= xfer_cnt + 8'h01;
            end
        end
    end

endmodule
